// File: rtl/regfile_access_arbiter_if.sv
// Bundle of every signal between regfile_access_arbiter and its neighbours: the core's
// file-register access, the register file port and the debug single-byte requester.
//   slave  : the arbiter's view (core/debug requests and rf read data in; rf port,
//            stall, debug completion and read data out).
//   master : the environment's view (core, debug requester and register file).
interface regfile_access_arbiter_if;
  // Core side
  logic [6:0] core_f_addr;
  logic       core_wr_en;
  logic [7:0] core_data_in;
  logic [7:0] core_f_data;
  logic [7:0] status_reg_val;
  logic [7:0] fsr_reg_val;
  logic       core_at_boundary;
  logic       core_stall;
  // Register file port
  logic [8:0] rf_addr;
  logic       rf_wr_en;
  logic [7:0] rf_data_in;
  logic [7:0] rf_data_out;
  // Debug requester
  logic       dbg_req;
  logic       dbg_we;
  logic [8:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_ack;
  logic       dbg_err;
  logic [7:0] dbg_rdata;

  modport slave (
    input  core_f_addr, core_wr_en, core_data_in, status_reg_val, fsr_reg_val,
           core_at_boundary, rf_data_out, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output core_f_data, core_stall, rf_addr, rf_wr_en, rf_data_in,
           dbg_ack, dbg_err, dbg_rdata
  );

  modport master (
    output core_f_addr, core_wr_en, core_data_in, status_reg_val, fsr_reg_val,
           core_at_boundary, rf_data_out, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  core_f_data, core_stall, rf_addr, rf_wr_en, rf_data_in,
           dbg_ack, dbg_err, dbg_rdata
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Owns the file-register port. Resolves core accesses (direct RP bank bits or INDF via
// IRP:FSR) and lets a debug requester do one byte read/write by stalling the core at an
// instruction boundary.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : regfile_access_arbiter_if.slave (core, register file and debug signals)
// Parameter:
//   DBG_WAIT_MAX : cycles to wait for a core boundary before aborting with dbg_err.
module regfile_access_arbiter #(
  parameter logic [15:0] DBG_WAIT_MAX = 16'd255
) (
  input logic                    clk,
  input logic                    rst,
  regfile_access_arbiter_if.slave bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWait    = 3'd1;
  localparam logic [2:0] StAccess  = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        dbg_we_q, dbg_we_d;
  logic [8:0]  dbg_addr_q, dbg_addr_d;
  logic [7:0]  dbg_wdata_q, dbg_wdata_d;
  logic        err_q, err_d;
  logic [7:0]  dbg_rdata_q, dbg_rdata_d;
  logic        null_q, null_d;
  logic        stall_q;

  logic [8:0]  core_addr;
  logic        in_access;
  logic [8:0]  mux_addr;
  logic        mux_null;
  logic [7:0]  rd_data;

  // f == 0 selects INDF: address comes from IRP:FSR, otherwise RP1:RP0:f.
  assign core_addr = (bus.core_f_addr == 7'd0) ?
                     {bus.status_reg_val[7], bus.fsr_reg_val} :
                     {bus.status_reg_val[6:5], bus.core_f_addr};

  assign in_access = (state_q == StAccess);
  assign mux_addr  = in_access ? dbg_addr_q : core_addr;
  // Offset 0 in any bank is INDF itself; an access through it reads 0 and never writes.
  assign mux_null  = (mux_addr[6:0] == 7'd0);
  assign null_d    = mux_null;

  assign bus.rf_addr    = mux_addr;
  assign bus.rf_wr_en   = (in_access ? dbg_we_q : bus.core_wr_en) & ~mux_null;
  assign bus.rf_data_in = in_access ? dbg_wdata_q : bus.core_data_in;

  assign rd_data          = null_q ? 8'h00 : bus.rf_data_out;
  assign bus.core_f_data  = rd_data;
  assign bus.core_stall   = stall_q;
  assign bus.dbg_ack      = (state_q == StDone);
  assign bus.dbg_err      = (state_q == StDone) & err_q;
  assign bus.dbg_rdata    = dbg_rdata_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dbg_we_d    = dbg_we_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_wdata_d = dbg_wdata_q;
    err_d       = err_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      StIdle: begin
        if (bus.dbg_req) begin
          dbg_we_d    = bus.dbg_we;
          dbg_addr_d  = bus.dbg_addr;
          dbg_wdata_d = bus.dbg_wdata;
          wait_cnt_d  = 16'd0;
          err_d       = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        // Boundary beats timeout. The counter stops at DBG_WAIT_MAX (<= 16'hFFFF), so it
        // never wraps; the abort ack lands DBG_WAIT_MAX + 2 cycles after the request.
        if (bus.core_at_boundary) begin
          state_d = StAccess;
        end else if (wait_cnt_q == DBG_WAIT_MAX) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StAccess: begin
        state_d = dbg_we_q ? StDone : StCapture;
      end
      StCapture: begin
        dbg_rdata_d = rd_data;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= 16'd0;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= 9'd0;
      dbg_wdata_q <= 8'h00;
      err_q       <= 1'b0;
      dbg_rdata_q <= 8'h00;
      null_q      <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dbg_we_q    <= dbg_we_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_wdata_q <= dbg_wdata_d;
      err_q       <= err_d;
      dbg_rdata_q <= dbg_rdata_d;
      null_q      <= null_d;
      // Registered stall: high for every non-idle state, drops as IDLE is entered.
      stall_q     <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
module tb_regfile_access_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic fill;
  always #5 clk = ~clk;

  regfile_access_arbiter_if bus ();

  regfile_access_arbiter #(
    .DBG_WAIT_MAX(16'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Register file model: registered read (read-before-write), filled with FF at start.
  logic [7:0] mem [512];
  logic [7:0] rf_q;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'hFF;
    end else if (bus.rf_wr_en) begin
      mem[bus.rf_addr] <= bus.rf_data_in;
    end
    rf_q <= mem[bus.rf_addr];
  end
  assign bus.rf_data_out = rf_q;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] st;
    logic [7:0] fsr;
    logic [6:0] f;
    logic       we;
    logic [7:0] d;
    logic [8:0] e_addr;
    logic       e_we;
    logic       chk_fd;
    logic [7:0] e_fd;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic core(input logic [7:0] st, input logic [7:0] fsr, input logic [6:0] f,
                      input logic we, input logic [7:0] d);
    bus.status_reg_val = st;
    bus.fsr_reg_val    = fsr;
    bus.core_f_addr    = f;
    bus.core_wr_en     = we;
    bus.core_data_in   = d;
  endtask

  // Debug read with boundary held high; called at the start of cycle T, returns in T+5.
  task automatic dbg_read(input logic [8:0] addr, input logic [7:0] exp, input string nm);
    bus.core_at_boundary = 1'b1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = addr; bus.dbg_wdata = 8'h00;
    #1 check({nm, " stall T"}, bus.core_stall, 0);
    tick(); bus.dbg_req = 1'b0;
    #1 check({nm, " stall T+1"}, bus.core_stall, 1);
    check({nm, " ack T+1"}, bus.dbg_ack, 0);
    tick();
    #1 check({nm, " rf_addr T+2"}, bus.rf_addr, addr);
    check({nm, " rf_wr_en T+2"}, bus.rf_wr_en, 0);
    tick();
    #1 check({nm, " ack T+3"}, bus.dbg_ack, 0);
    check({nm, " stall T+3"}, bus.core_stall, 1);
    tick();
    #1 check({nm, " ack T+4"}, bus.dbg_ack, 1);
    check({nm, " err T+4"}, bus.dbg_err, 0);
    check({nm, " rdata T+4"}, bus.dbg_rdata, exp);
    check({nm, " stall T+4"}, bus.core_stall, 1);
    tick();
    #1 check({nm, " stall T+5"}, bus.core_stall, 0);
    check({nm, " ack T+5"}, bus.dbg_ack, 0);
    check({nm, " rdata T+5"}, bus.dbg_rdata, exp);
  endtask

  initial begin
    //          st     fsr    f      we    d      addr    we    chk   fd
    vecs[0] = '{8'h40, 8'h00, 7'h20, 1'b1, 8'hA5, 9'h120, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{8'h40, 8'h00, 7'h20, 1'b0, 8'h00, 9'h120, 1'b0, 1'b1, 8'hFF};
    vecs[2] = '{8'h80, 8'h30, 7'h00, 1'b0, 8'h00, 9'h130, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{8'h80, 8'h30, 7'h00, 1'b1, 8'h77, 9'h130, 1'b1, 1'b1, 8'hFF};
    vecs[4] = '{8'h80, 8'h30, 7'h00, 1'b0, 8'h00, 9'h130, 1'b0, 1'b1, 8'hFF};
    vecs[5] = '{8'h80, 8'h80, 7'h00, 1'b1, 8'h99, 9'h180, 1'b0, 1'b1, 8'h77};
    vecs[6] = '{8'h20, 8'h00, 7'h05, 1'b0, 8'h00, 9'h085, 1'b0, 1'b1, 8'h00};
    vecs[7] = '{8'hE0, 8'h00, 7'h7F, 1'b0, 8'h00, 9'h1FF, 1'b0, 1'b1, 8'hFF};
    vecs[8] = '{8'h00, 8'h00, 7'h00, 1'b0, 8'h00, 9'h000, 1'b0, 1'b1, 8'hFF};
    vecs[9] = '{8'h00, 8'h7F, 7'h01, 1'b0, 8'h00, 9'h001, 1'b0, 1'b1, 8'h00};

    rst = 1'b1; fill = 1'b1;
    core(8'h00, 8'h00, 7'h00, 1'b0, 8'h00);
    bus.core_at_boundary = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 9'd0; bus.dbg_wdata = 8'h00;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0; fill = 1'b0;
    #1 check("reset stall", bus.core_stall, 0);
    check("reset ack", bus.dbg_ack, 0);
    check("reset err", bus.dbg_err, 0);
    check("reset rdata", bus.dbg_rdata, 8'h00);

    // Core address resolution, null INDF rule and one-cycle read latency
    for (int i = 0; i < 10; i++) begin
      core(vecs[i].st, vecs[i].fsr, vecs[i].f, vecs[i].we, vecs[i].d);
      #1 check($sformatf("vec%0d rf_addr", i), bus.rf_addr, vecs[i].e_addr);
      check($sformatf("vec%0d rf_wr_en", i), bus.rf_wr_en, vecs[i].e_we);
      if (vecs[i].chk_fd) check($sformatf("vec%0d core_f_data", i), bus.core_f_data,
                                vecs[i].e_fd);
      tick();
    end

    // Preload 0x0A0 = 5C through a core write (RP=01, f=20)
    core(8'h20, 8'h00, 7'h20, 1'b1, 8'h5C);
    #1 check("preload rf_addr", bus.rf_addr, 9'h0A0);
    tick();
    core(8'h00, 8'h00, 7'h20, 1'b0, 8'h00);

    dbg_read(9'h080, 8'h00, "dbg null read");
    tick();
    dbg_read(9'h0A0, 8'h5C, "dbg read");
    tick();

    // Debug write with boundary delayed; core keeps writing 4B to 0x020 meanwhile
    core(8'h00, 8'h00, 7'h20, 1'b1, 8'h4B);
    bus.core_at_boundary = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 9'h071; bus.dbg_wdata = 8'h3E;
    tick(); bus.dbg_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1 check($sformatf("wr wait%0d stall", k), bus.core_stall, 1);
      check($sformatf("wr wait%0d core rf_wr_en", k), bus.rf_wr_en, 1);
      check($sformatf("wr wait%0d rf_data_in", k), bus.rf_data_in, 8'h4B);
      tick();
    end
    bus.core_at_boundary = 1'b1;
    #1 check("wr T+4 ack", bus.dbg_ack, 0);
    tick();
    #1 check("wr access rf_addr", bus.rf_addr, 9'h071);
    check("wr access rf_wr_en", bus.rf_wr_en, 1);
    check("wr access rf_data_in", bus.rf_data_in, 8'h3E);
    check("wr T+5 ack", bus.dbg_ack, 0);
    tick();
    core(8'h00, 8'h00, 7'h20, 1'b0, 8'h00);
    #1 check("wr T+6 ack", bus.dbg_ack, 1);
    check("wr T+6 err", bus.dbg_err, 0);
    tick();
    #1 check("wr T+7 stall", bus.core_stall, 0);
    tick();
    core(8'h00, 8'h00, 7'h71, 1'b0, 8'h00);
    #1 check("readback core 020", bus.core_f_data, 8'h4B);
    tick();
    #1 check("readback dbg 071", bus.core_f_data, 8'h3E);
    tick();

    // Timeout: boundary never comes, DBG_WAIT_MAX = 4
    bus.core_at_boundary = 1'b0;
    core(8'h00, 8'h00, 7'h20, 1'b0, 8'h00);
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 9'h055; bus.dbg_wdata = 8'h11;
    tick(); bus.dbg_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1 check($sformatf("to T+%0d stall", k), bus.core_stall, 1);
      check($sformatf("to T+%0d ack", k), bus.dbg_ack, 0);
      check($sformatf("to T+%0d rf_wr_en", k), bus.rf_wr_en, 0);
      tick();
    end
    #1 check("to T+6 ack", bus.dbg_ack, 1);
    check("to T+6 err", bus.dbg_err, 1);
    check("to T+6 rf_wr_en", bus.rf_wr_en, 0);
    tick();
    core(8'h00, 8'h00, 7'h55, 1'b0, 8'h00);
    #1 check("to T+7 stall", bus.core_stall, 0);
    check("to T+7 ack", bus.dbg_ack, 0);
    check("to T+7 err", bus.dbg_err, 0);
    check("to rdata held", bus.dbg_rdata, 8'h5C);
    tick();
    #1 check("to 055 untouched", bus.core_f_data, 8'hFF);
    tick();

    // Reset while in CAPTURE, then an immediate new request
    core(8'h00, 8'h00, 7'h20, 1'b0, 8'h00);
    bus.core_at_boundary = 1'b1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 9'h0A0;
    tick(); bus.dbg_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1 check("rst capture ack", bus.dbg_ack, 0);
    tick();
    rst = 1'b0;
    #1 check("rst after stall", bus.core_stall, 0);
    check("rst after ack", bus.dbg_ack, 0);
    check("rst after err", bus.dbg_err, 0);
    check("rst after rdata", bus.dbg_rdata, 8'h00);
    dbg_read(9'h0A0, 8'h5C, "post-rst read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
